// File: rtl/spi_master_byte.sv
// Single-byte SPI master, mode 0 (CPOL=0, CPHA=0), MSB first, full duplex.
// Each transfer frames its own cs_n low window and pulses done on completion.
module spi_master_byte #(
  parameter int unsigned HALF_PERIOD = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data_in,
  output logic       done,
  output logic [7:0] data_out,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso,
  output logic       cs_n
);

  localparam int unsigned PW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(HALF_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] phase;
  logic [2:0]    bit_cnt;
  logic [7:0]    tx_shift;
  logic [7:0]    rx_shift;
  logic          phase_end;

  assign phase_end = (phase == PH_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // bit_cnt names the bit on the wire for the current HIGH/LOW pair, so the
  // LOW exit can tell "next bit" from "CS hold done" without an extra flag.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)     state_nxt = SETUP;
      SETUP:   if (phase_end) state_nxt = HIGH;
      HIGH:    if (phase_end) state_nxt = LOW;
      LOW:     if (phase_end) state_nxt = (bit_cnt == 3'd0) ? IDLE : HIGH;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sclk = (state == HIGH);
    cs_n = (state == IDLE);
    mosi = (state != IDLE) && tx_shift[7];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase    <= '0;
      bit_cnt  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      data_out <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE || phase_end) phase <= '0;
      else                            phase <= phase + PW'(1);
      case (state)
        IDLE: begin
          if (start) begin
            tx_shift <= data_in;
            bit_cnt  <= 3'd7;
          end
        end
        HIGH: begin
          if (phase_end) begin
            rx_shift <= {rx_shift[6:0], miso};
            if (bit_cnt != 3'd0) tx_shift <= {tx_shift[6:0], 1'b0};
          end
        end
        LOW: begin
          if (phase_end) begin
            if (bit_cnt == 3'd0) begin
              done     <= 1'b1;
              data_out <= rx_shift;
            end else begin
              bit_cnt <= bit_cnt - 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_byte.sv
// Directed and randomized bench for spi_master_byte at HALF_PERIOD=2 and 1,
// checked against a bit-level model of the SPI mode-0 byte exchange.
module tb_spi_master_byte;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       sel = 1'b0;
  logic [7:0] data_in = '0;
  logic       miso = 1'b0;

  logic       start0, start1;
  logic       done0, done1, sclk0, sclk1, mosi0, mosi1, cs_n0, cs_n1;
  logic [7:0] data_out0, data_out1;
  logic       o_done, o_sclk, o_mosi, o_cs_n;
  logic [7:0] o_data_out;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  assign start0 = start & ~sel;
  assign start1 = start & sel;
  assign o_done     = sel ? done1     : done0;
  assign o_sclk     = sel ? sclk1     : sclk0;
  assign o_mosi     = sel ? mosi1     : mosi0;
  assign o_cs_n     = sel ? cs_n1     : cs_n0;
  assign o_data_out = sel ? data_out1 : data_out0;

  spi_master_byte #(.HALF_PERIOD(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .data_in(data_in), .done(done0),
    .data_out(data_out0), .sclk(sclk0), .mosi(mosi0), .miso(miso), .cs_n(cs_n0)
  );

  spi_master_byte #(.HALF_PERIOD(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .data_in(data_in), .done(done1),
    .data_out(data_out1), .sclk(sclk1), .mosi(mosi1), .miso(miso), .cs_n(cs_n1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic kick(input logic [7:0] tx);
    start   = 1'b1;
    data_in = tx;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " sclk"},  32'(o_sclk), 32'd0);
    check({tag, " cs_n"},  32'(o_cs_n), 32'd1);
    check({tag, " mosi"},  32'(o_mosi), 32'd0);
    check({tag, " done"},  32'(o_done), 32'd0);
  endtask

  // Watch n cycles with no start: no done pulse and cs_n must stay high.
  task automatic quiet(input int unsigned n, input string tag);
    int unsigned dones = 0;
    int unsigned cs_low = 0;
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      if (o_done)  dones++;
      if (!o_cs_n) cs_low++;
    end
    check({tag, " stray_done"}, dones, 32'd0);
    check({tag, " stray_cs"},   cs_low, 32'd0);
  endtask

  // Caller has start/data_in driven at a negedge. Model: one sclk rise per
  // bit, mosi = tx MSB first, rx = miso at each rise, cs_n low 17*hp cycles,
  // done in the cycle starting 17*hp edges after acceptance.
  task automatic xfer(input logic [7:0] tx, input logic [7:0] rx_pat, input bit loopback,
                      input bit chain, input logic [7:0] nxt, input bit poke, input string tag);
    int unsigned hp = sel ? 1 : 2;
    int unsigned rises = 0;
    int unsigned cs_low = 0;
    int unsigned done_idx = 999;
    int unsigned k = 0;
    bit          seen = 1'b0;
    bit          prev_sclk = 1'b0;
    bit          cs_at_done = 1'b0;
    logic [7:0]  mosi_bits = '0;
    logic [7:0]  rx_exp = loopback ? tx : rx_pat;
    if (!loopback) miso = rx_pat[7];
    @(posedge clk);
    #1;
    start   = 1'b0;
    data_in = 8'($urandom);
    for (int unsigned idx = 0; idx < 17 * hp + 4 && !seen; idx++) begin
      @(negedge clk);
      if (poke && idx == 5 * hp)     begin start = 1'b1; data_in = 8'h3C; end
      if (poke && idx == 5 * hp + 1) start = 1'b0;
      if (o_done) begin
        seen       = 1'b1;
        done_idx   = idx;
        cs_at_done = o_cs_n;
      end else begin
        if (!o_cs_n) cs_low++;
        if (o_sclk && !prev_sclk) begin
          if (rises < 8) mosi_bits[7 - rises] = o_mosi;
          rises++;
        end
        if (!o_sclk && prev_sclk && !loopback) begin
          k++;
          if (k < 8) miso = rx_pat[7 - k];
        end
        prev_sclk = o_sclk;
      end
      if (loopback) miso = o_mosi;
    end
    check({tag, " done_latency"}, done_idx, 17 * hp);
    check({tag, " cs_low_cycles"}, cs_low, 17 * hp);
    check({tag, " sclk_rises"}, rises, 32'd8);
    check({tag, " mosi_bits"}, 32'(mosi_bits), 32'(tx));
    check({tag, " data_out"}, 32'(o_data_out), 32'(rx_exp));
    check({tag, " cs_at_done"}, 32'(cs_at_done), 32'd1);
    if (chain) kick(nxt);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned rises;
    bit          prev;
    logic [7:0]  tx, rp;

    repeat (10) @(negedge clk);
    sel = 1'b0;
    check_idle("reset hp2");
    check("reset hp2 data_out", 32'(o_data_out), 32'd0);
    sel = 1'b1;
    #1;
    check_idle("reset hp1");
    check("reset hp1 data_out", 32'(o_data_out), 32'd0);
    sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    kick(8'h01);
    xfer(8'h01, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, "x01_miso1");
    @(negedge clk);
    check_idle("x01 after");
    check("x01 held data_out", 32'(o_data_out), 32'hFF);

    kick(8'hA5);
    xfer(8'hA5, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, "xA5_loop");
    @(negedge clk);

    kick(8'h10);
    xfer(8'h10, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, "b2b_0");
    xfer(8'h00, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, "b2b_1");
    xfer(8'h00, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, "b2b_2");
    xfer(8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, "b2b_3");
    quiet(5, "b2b tail");

    kick(8'hC3);
    xfer(8'hC3, 8'h96, 1'b0, 1'b0, 8'h00, 1'b1, "midstart");
    quiet(40, "midstart tail");

    kick(8'h5A);
    @(posedge clk);
    #1;
    start = 1'b0;
    rises = 0;
    prev  = 1'b0;
    for (int unsigned i = 0; i < 60 && rises < 4; i++) begin
      @(negedge clk);
      if (o_sclk && !prev) rises++;
      prev = o_sclk;
    end
    check("rst 4th_high reached", rises, 32'd4);
    check("rst sclk_high_before", 32'(o_sclk), 32'd1);
    rst_n = 1'b0;
    #1;
    check_idle("rst mid");
    check("rst mid data_out", 32'(o_data_out), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    quiet(40, "rst aftermath");
    @(negedge clk);
    kick(8'h02);
    xfer(8'h02, 8'h81, 1'b0, 1'b0, 8'h00, 1'b0, "post_rst x02");
    @(negedge clk);

    sel = 1'b1;
    @(negedge clk);
    kick(8'h01);
    xfer(8'h01, 8'hFF, 1'b0, 1'b1, 8'h7E, 1'b0, "hp1 b2b_0");
    xfer(8'h7E, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, "hp1 b2b_1");
    quiet(20, "hp1 tail");

    for (int unsigned i = 0; i < 8; i++) begin
      sel = i[0];
      tx  = 8'($urandom);
      rp  = 8'($urandom);
      @(negedge clk);
      kick(tx);
      xfer(tx, rp, 1'($urandom_range(0, 1)), 1'b0, 8'h00, 1'b0, $sformatf("rand%0d", i));
      @(negedge clk);
      check_idle($sformatf("rand%0d idle", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
